// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback path.
// Default register widths and the writeback entry layout.
package wb_arbiter_pkg;

  localparam int CORE_DATA_W = 16;
  localparam int CORE_ADDR_W = 4;

  typedef struct packed {
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO buffering multi-cycle results.
// Caller guarantees no push when full and no pop when empty.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int W     = $bits(wb_entry_t),
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage array; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, multi-cycle results queue.
// Also tracks which registers await a multi-cycle result.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = CORE_DATA_W,
  parameter int ADDR_W     = CORE_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mc_valid,
  input  logic [ADDR_W-1:0]    mc_addr,
  input  logic [DATA_W-1:0]    mc_data,
  output logic                 mc_ready,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data
);

  localparam int EW = ADDR_W + DATA_W;

  logic                          push;
  logic                          pop;
  logic [EW-1:0]                 head;
  logic [ADDR_W-1:0]             head_addr;
  logic [DATA_W-1:0]             head_data;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  logic                          full;
  logic                          empty;
  logic [2**ADDR_W-1:0]          busy_next;

  assign mc_ready = !full;
  assign push     = mc_valid && mc_ready;
  assign pop      = !alu_valid && !empty;
  assign head_addr = head[EW-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  wb_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({mc_addr, mc_data}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Scoreboard update: a new issue overrides a same-cycle retire.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_addr] = 1'b0;
    if (issue_valid) busy_next[issue_addr] = 1'b1;
  end

  // Registered write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= '0;
    end else begin
      busy  <= busy_next;
      wr_en <= alu_valid || pop;
      unique case (1'b1)
        alu_valid: begin
          wr_addr <= alu_addr;
          wr_data <= alu_data;
        end
        pop: begin
          wr_addr <= head_addr;
          wr_data <= head_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          alu_valid = 0;
  logic [AW-1:0] alu_addr = 0;
  logic [DW-1:0] alu_data = 0;
  logic          mc_valid = 0;
  logic [AW-1:0] mc_addr = 0;
  logic [DW-1:0] mc_data = 0;
  logic          mc_ready;
  logic          issue_valid = 0;
  logic [AW-1:0] issue_addr = 0;
  logic [15:0]   busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  wb_entry_t fifo_m[$];
  wb_entry_t exp_q[$];
  bit        busy_m[16];
  logic [AW-1:0] last_addr = 0;
  logic [DW-1:0] last_data = 0;

  wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
    .mc_ready(mc_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Model clears on reset assertion, like the hardware does.
  always @(negedge rst_n) begin
    fifo_m.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) busy_m[i] = 0;
    last_addr = 0;
    last_data = 0;
  end

  // Reference model: evaluates the selection rules at each edge.
  always @(posedge clk) begin
    if (rst_n) begin
      wb_entry_t e;
      bit ready, popped;
      logic [AW-1:0] pa;
      ready  = fifo_m.size() < DEPTH;
      popped = 0;
      pa     = 0;
      if (alu_valid) begin
        e.addr = alu_addr;
        e.data = alu_data;
        exp_q.push_back(e);
      end else if (fifo_m.size() > 0) begin
        e = fifo_m.pop_front();
        exp_q.push_back(e);
        popped = 1;
        pa = e.addr;
      end
      if (mc_valid && ready) begin
        e.addr = mc_addr;
        e.data = mc_data;
        fifo_m.push_back(e);
      end
      if (popped) busy_m[pa] = 0;
      if (issue_valid) busy_m[issue_addr] = 1;
    end
  end

  // Monitor: each expected write must appear exactly one cycle later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 32'(wr_en), 32'd0);
        end else begin
          wb_entry_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("hold_addr", 32'(wr_addr), 32'(last_addr));
        check("hold_data", 32'(wr_data), 32'(last_data));
      end
      if (exp_q.size() != 0) begin
        check("missing_wr", 32'(wr_en), 32'd1);
        exp_q.delete();
      end
      check("busy", 32'(busy), 32'(busy_vec()));
      check("mc_ready", 32'(mc_ready), 32'(fifo_m.size() < DEPTH));
    end
  end

  task automatic drive(input bit av, input int aa, input int ad,
                       input bit mv, input int ma, input int md,
                       input bit iv, input int ia);
    @(negedge clk);
    alu_valid = av; alu_addr = AW'(aa); alu_data = DW'(ad);
    mc_valid = mv; mc_addr = AW'(ma); mc_data = DW'(md);
    issue_valid = iv; issue_addr = AW'(ia);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    logic [DW-1:0] vals [3];
    #12 rst_n = 1;
    idle(2);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(mc_ready), 32'd1);

    drive(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    idle(2);

    drive(0, 0, 0, 0, 0, 0, 1, 5);
    idle(2);
    drive(0, 0, 0, 1, 5, 16'hBEEF, 0, 0);
    idle(4);

    vals[0] = 16'hA001; vals[1] = 16'hA002; vals[2] = 16'hA003;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1, c, 16'h5000 + c, k < 3, 8 + k, k < 3 ? vals[k] : 0, 0, 0);
      if (k < 3 && mc_ready) k++;
    end
    while (k < 3) begin
      drive(0, 0, 0, 1, 8 + k, vals[k], 0, 0);
      if (mc_ready) k++;
    end
    idle(5);

    drive(0, 0, 0, 0, 0, 0, 1, 7);
    drive(0, 0, 0, 1, 7, 16'h7777, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    idle(2);
    check("busy7_kept", 32'(busy[7]), 32'd1);

    drive(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0);
    drive(1, 1, 16'h1112, 1, 3, 16'h3333, 1, 9);
    drive(1, 1, 16'h1113, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(mc_ready), 32'd1);
    alu_valid = 0;
    idle(2);
    #2 rst_n = 1;
    idle(3);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 15),
            $urandom_range(0, 65535), $urandom_range(0, 1) == 1,
            $urandom_range(0, 15), $urandom_range(0, 65535),
            $urandom_range(0, 3) == 0, $urandom_range(0, 15));
      if (c == 1500) begin
        #2 rst_n = 0;
        #1 check("rnd_rst_wr_en", 32'(wr_en), 32'd0);
        idle(1);
        #2 rst_n = 1;
      end
    end
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
